// File: rtl/dmem_pkg.sv
// dmem_pkg: shared geometry, size/state encodings and byte-count helper for the data-memory port controller
package dmem_pkg;
  localparam int LANES = 4;
  localparam int ROW_W = 14;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_RSV} size_e;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  function automatic logic [2:0] size_bytes(input size_e s);
    return s == SZ_B ? 3'd1 : s == SZ_H ? 3'd2 : s == SZ_W ? 3'd4 : 3'd0;
  endfunction
endpackage

// File: rtl/dmem_lane_map.sv
// dmem_lane_map: byte-lane rotation, per-lane row/wren/wdata and load extension (DMEM_MISALIGN_EN enables lane-crossing accesses)
module dmem_lane_map
  import dmem_pkg::*;
(
  input  logic                         active,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         we,
  input  size_e                        size,
  input  logic                         uns,
  input  logic [31:0]                  wdata,
  input  logic [LANES-1:0][7:0]        bank_rdata,
  output logic [LANES-1:0][ROW_W-1:0]  bank_addr,
  output logic [LANES-1:0]             bank_wren,
  output logic [LANES-1:0][7:0]        bank_wdata,
  output logic [31:0]                  rdata,
  output logic                         err
);
  logic [1:0] lane0;
  logic [ROW_W-1:0] row;
  logic [2:0] nbytes;
  logic [LANES-1:0][7:0] raw;
  assign lane0 = addr[1:0];
  assign row = addr[ADDR_W-1:2];
  assign nbytes = size_bytes(size);
`ifdef DMEM_MISALIGN_EN
  assign err = size == SZ_RSV;
`else
  assign err = size == SZ_RSV || ({1'b0, lane0} + nbytes) > 3'd4;
`endif
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [1:0] k;
    logic cov;
    assign k = 2'(g) - lane0;
    assign cov = {1'b0, k} < nbytes;
    assign bank_addr[g] = row + ROW_W'(cov && (2'(g) < lane0));
    assign bank_wren[g] = active && we && cov && !err;
    assign bank_wdata[g] = wdata[{k, 3'b000} +: 8];
    assign raw[g] = bank_rdata[2'(g) + lane0];
  end
  assign rdata = (err || we) ? '0 :
                 size == SZ_B ? {{24{~uns & raw[0][7]}}, raw[0]} :
                 size == SZ_H ? {{16{~uns & raw[1][7]}}, raw[1], raw[0]} : raw;
endmodule

// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: two-port round-robin controller for the four byte-lane data banks (DMEM_MISALIGN_EN enables misaligned access)
module dmem_port_ctrl
  import dmem_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   req_valid_i,
  output logic [1:0]                   req_ready_o,
  input  logic [1:0][ADDR_W-1:0]       req_addr_i,
  input  logic [1:0]                   req_we_i,
  input  logic [1:0][1:0]              req_size_i,
  input  logic [1:0]                   req_unsigned_i,
  input  logic [1:0][31:0]             req_wdata_i,
  output logic                         rsp_valid_o,
  output logic                         rsp_id_o,
  output logic [31:0]                  rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic [LANES-1:0][ROW_W-1:0]  bank_addr_o,
  output logic [LANES-1:0]             bank_wren_o,
  output logic [LANES-1:0][7:0]        bank_wdata_o,
  input  logic [LANES-1:0][7:0]        bank_rdata_i
);
  state_e state, state_nx;
  logic rr_ptr, gnt, accept;
  logic [ADDR_W-1:0] a_addr;
  logic a_we, a_uns, a_id;
  size_e a_size;
  logic [31:0] a_wdata, map_rdata;
  logic map_err;
  // state register; reset drops any in-flight request
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= IDLE;
    else state <= state_nx;
  // arbitration, handshake and next state; RESP also accepts to sustain one access per two cycles
  always_comb begin
    gnt = &req_valid_i ? rr_ptr : req_valid_i[1];
    accept = !rst_i && state != ACCESS && |req_valid_i;
    req_ready_o = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid_o = state == RESP;
    state_nx = state == ACCESS ? RESP : accept ? ACCESS : IDLE;
  end
  // request latch, round-robin pointer and registered response
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rr_ptr <= 1'b0;
      a_addr <= '0;
      a_we <= 1'b0;
      a_size <= SZ_B;
      a_uns <= 1'b0;
      a_wdata <= '0;
      a_id <= 1'b0;
      rsp_id_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= ~gnt;
        a_addr <= req_addr_i[gnt];
        a_we <= req_we_i[gnt];
        a_size <= size_e'(req_size_i[gnt]);
        a_uns <= req_unsigned_i[gnt];
        a_wdata <= req_wdata_i[gnt];
        a_id <= gnt;
      end
      if (state == ACCESS) begin
        rsp_id_o <= a_id;
        rsp_rdata_o <= map_rdata;
        rsp_err_o <= map_err;
      end
    end
  dmem_lane_map u_map (
    .active     (state == ACCESS),
    .addr       (a_addr),
    .we         (a_we),
    .size       (a_size),
    .uns        (a_uns),
    .wdata      (a_wdata),
    .bank_rdata (bank_rdata_i),
    .bank_addr  (bank_addr_o),
    .bank_wren  (bank_wren_o),
    .bank_wdata (bank_wdata_o),
    .rdata      (map_rdata),
    .err        (map_err)
  );
endmodule

// File: tb/tb_dmem_port_ctrl.sv
// tb_dmem_port_ctrl: table-driven and scoreboarded bench with a four-bank memory model
module tb_dmem_port_ctrl;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [1:0] req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [1:0][15:0] req_addr_i;
  logic [1:0][1:0] req_size_i;
  logic [1:0][31:0] req_wdata_i;
  logic rsp_valid_o, rsp_id_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [3:0][13:0] bank_addr_o;
  logic [3:0] bank_wren_o;
  logic [3:0][7:0] bank_wdata_o, bank_rdata_i;
  typedef struct {
    int port;
    logic [15:0] addr;
    logic we;
    logic [1:0] size;
    logic uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic exp_err;
  } vec_t;
  typedef struct {
    logic id;
    logic [31:0] rdata;
    logic err;
    int cyc;
  } exp_t;
  vec_t vt[$];
  exp_t sb[$];
  exp_t mon_e;
  int n_vec = 0, n_bad = 0, cyc = 0, wr_tot = 0, snap;
  int wr_cnt [4];
  logic [7:0] mem [4][16384];
  logic mem_clr;
  int gq[$], aq[$];

  always #5 clk_i = ~clk_i;

  dmem_port_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_we_i(req_we_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .bank_addr_o(bank_addr_o), .bank_wren_o(bank_wren_o), .bank_wdata_o(bank_wdata_o),
    .bank_rdata_i(bank_rdata_i)
  );

  for (genvar g = 0; g < 4; g++) begin : g_bank
    assign bank_rdata_i[g] = mem[g][bank_addr_o[g]];
  end

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int l = 0; l < 4; l++) begin
        wr_cnt[l] <= 0;
        for (int r = 0; r < 16384; r++) mem[l][r] <= 8'h00;
      end
      wr_tot <= 0;
    end else begin
      for (int l = 0; l < 4; l++)
        if (bank_wren_o[l]) begin
          mem[l][bank_addr_o[l]] <= bank_wdata_o[l];
          wr_cnt[l] <= wr_cnt[l] + 1;
        end
      if (|bank_wren_o) wr_tot <= wr_tot + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  always @(negedge clk_i)
    if (!rst_i && rsp_valid_o) begin
      if (sb.size() == 0) bound_fail("unexpected_rsp");
      else begin
        mon_e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id_o), 32'(mon_e.id));
        chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(mon_e.err));
        chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end

  task automatic send(input int p, input logic [15:0] addr, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    int n = 0;
    @(negedge clk_i);
    req_valid_i[p] = 1'b1;
    req_addr_i[p] = addr;
    req_we_i[p] = we;
    req_size_i[p] = size;
    req_unsigned_i[p] = uns;
    req_wdata_i[p] = wdata;
    #1;
    while (!req_ready_o[p] && n < 20) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (!req_ready_o[p]) bound_fail("accept_wait");
    else begin
      sb.push_back('{p[0], er, ee, cyc + 2});
      @(posedge clk_i);
      #1;
    end
    req_valid_i[p] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() > 0) begin
      bound_fail("rsp_wait");
      sb.delete();
    end
    @(negedge clk_i);
  endtask

  task automatic pulse_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  function automatic logic [31:0] dual_data(input int p, input int i);
    return {8'hA0 + 8'(p), 8'(i), 16'h5A5A};
  endfunction

  task automatic drive_dual(input int p, input int i, input logic we);
    req_valid_i[p] = i < 4;
    req_addr_i[p] = 16'h0100 + 16'(p * 32 + i * 4);
    req_we_i[p] = we;
    req_size_i[p] = 2'd2;
    req_unsigned_i[p] = 1'b0;
    req_wdata_i[p] = dual_data(p, i);
  endtask

  task automatic run_dual(input logic we);
    int idx [2];
    int t = 0;
    idx[0] = 0;
    idx[1] = 0;
    gq.delete();
    aq.delete();
    @(posedge clk_i);
    #1;
    drive_dual(0, 0, we);
    drive_dual(1, 0, we);
    while ((idx[0] < 4 || idx[1] < 4) && t < 60) begin
      @(negedge clk_i);
      #1;
      for (int p = 0; p < 2; p++)
        if (req_valid_i[p] && req_ready_o[p]) begin
          sb.push_back('{p[0], we ? 32'h0 : dual_data(p, idx[p]), 1'b0, cyc + 2});
          gq.push_back(p);
          aq.push_back(cyc);
          idx[p]++;
        end
      @(posedge clk_i);
      #1;
      for (int p = 0; p < 2; p++) drive_dual(p, idx[p], we);
      t++;
    end
    req_valid_i = 2'b00;
    if (idx[0] < 4 || idx[1] < 4) bound_fail("dual_accept");
    for (int i = 0; i < gq.size(); i++) chk("grant_order", 32'(gq[i]), 32'(i % 2));
    for (int i = 1; i < aq.size(); i++) chk("accept_gap", 32'(aq[i] - aq[i-1]), 32'd2);
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    mem_clr = 1'b1;
    req_valid_i = 2'b11;
    req_addr_i = '0;
    req_we_i = '0;
    req_size_i = '0;
    req_unsigned_i = '0;
    req_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_ready", 32'(req_ready_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id_o), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err_o), 32'd0);
    chk("reset_wren", 32'(bank_wren_o), 32'd0);
    req_valid_i = 2'b00;
    mem_clr = 1'b0;
    rst_i = 1'b0;

    send(0, 16'h0010, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    drain();
    for (int l = 0; l < 4; l++) chk("store_lane_writes", 32'(wr_cnt[l]), 32'd1);
    chk("store_bank0", 32'(mem[0][4]), 32'hEF);
    chk("store_bank3", 32'(mem[3][4]), 32'hDE);

    vt.push_back('{0, 16'h0010, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0});
    vt.push_back('{0, 16'h0013, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0});
    vt.push_back('{0, 16'h0013, 1'b0, 2'd0, 1'b1, 32'h0, 32'h000000DE, 1'b0});
    vt.push_back('{0, 16'h0012, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0});
    vt.push_back('{0, 16'h0010, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0000BEEF, 1'b0});
    vt.push_back('{0, 16'h0011, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0});
    vt.push_back('{1, 16'h0010, 1'b0, 2'd2, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0});
    vt.push_back('{0, 16'h0020, 1'b1, 2'd3, 1'b0, 32'hCAFEF00D, 32'h0, 1'b1});
    vt.push_back('{1, 16'h0020, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0});
    vt.push_back('{0, 16'h0010, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1});
    vt.push_back('{1, 16'h0022, 1'b1, 2'd1, 1'b0, 32'h1234A5A5, 32'h0, 1'b0});
    vt.push_back('{0, 16'h0020, 1'b0, 2'd2, 1'b0, 32'h0, 32'hA5A50000, 1'b0});
    vt.push_back('{0, 16'h0021, 1'b1, 2'd0, 1'b0, 32'hFFFFFF7F, 32'h0, 1'b0});
    vt.push_back('{1, 16'h0020, 1'b0, 2'd2, 1'b0, 32'h0, 32'hA5A57F00, 1'b0});
    vt.push_back('{0, 16'h0022, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFFA5A5, 1'b0});
`ifdef DMEM_MISALIGN_EN
    vt.push_back('{0, 16'h0013, 1'b0, 2'd1, 1'b0, 32'h0, 32'h000000DE, 1'b0});
    vt.push_back('{1, 16'h0011, 1'b0, 2'd2, 1'b0, 32'h0, 32'h00DEADBE, 1'b0});
    vt.push_back('{0, 16'h0023, 1'b1, 2'd1, 1'b0, 32'h00009988, 32'h0, 1'b0});
    vt.push_back('{0, 16'h0020, 1'b0, 2'd2, 1'b0, 32'h0, 32'h88A57F00, 1'b0});
    vt.push_back('{1, 16'h0024, 1'b0, 2'd2, 1'b0, 32'h0, 32'h00000099, 1'b0});
`else
    vt.push_back('{0, 16'h0013, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1});
    vt.push_back('{1, 16'h0011, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1});
    vt.push_back('{0, 16'h0023, 1'b1, 2'd1, 1'b0, 32'h00009988, 32'h0, 1'b1});
    vt.push_back('{0, 16'h0020, 1'b0, 2'd2, 1'b0, 32'h0, 32'hA5A57F00, 1'b0});
    vt.push_back('{1, 16'h0024, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0});
`endif
    for (int i = 0; i < vt.size(); i++)
      send(vt[i].port, vt[i].addr, vt[i].we, vt[i].size, vt[i].uns, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err);
    drain();

    snap = wr_tot;
`ifdef DMEM_MISALIGN_EN
    send(0, 16'hFFFF, 1'b1, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0);
    drain();
    chk("wrap_lane3_top", 32'(mem[3][16383]), 32'h44);
    chk("wrap_lane0_row0", 32'(mem[0][0]), 32'h33);
    chk("wrap_lane1_row0", 32'(mem[1][0]), 32'h22);
    chk("wrap_lane2_row0", 32'(mem[2][0]), 32'h11);
    send(1, 16'h0000, 1'b0, 2'd2, 1'b0, 32'h0, 32'h00112233, 1'b0);
    send(0, 16'hFFFF, 1'b0, 2'd0, 1'b1, 32'h0, 32'h00000044, 1'b0);
`else
    send(0, 16'hFFFF, 1'b1, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b1);
    drain();
    chk("wrap_no_write", 32'(wr_tot), 32'(snap));
    chk("wrap_lane3_top", 32'(mem[3][16383]), 32'h00);
    send(1, 16'h0000, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    send(0, 16'hFFFF, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0, 1'b0);
`endif
    drain();

    pulse_reset();
    run_dual(1'b1);
    run_dual(1'b0);

    send(0, 16'h0010, 1'b0, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    drain();
    snap = wr_tot;
    @(negedge clk_i);
    req_valid_i[0] = 1'b1;
    req_addr_i[0] = 16'h0040;
    req_we_i[0] = 1'b1;
    req_size_i[0] = 2'd2;
    req_unsigned_i[0] = 1'b0;
    req_wdata_i[0] = 32'h55667788;
    #1;
    chk("rst_case_ready", 32'(req_ready_o), 32'h1);
    @(posedge clk_i);
    #1;
    req_valid_i = 2'b00;
    chk("access_wren", 32'(bank_wren_o), 32'hF);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_wren_drop", 32'(bank_wren_o), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_no_write", 32'(wr_tot), 32'(snap));
    req_valid_i = 2'b11;
    req_addr_i[0] = 16'h0040;
    req_addr_i[1] = 16'h0040;
    req_we_i = 2'b00;
    req_size_i[0] = 2'd2;
    req_size_i[1] = 2'd2;
    #1;
    chk("rst_rr_grant", 32'(req_ready_o), 32'h1);
    if (req_ready_o[0]) sb.push_back('{1'b0, 32'h0, 1'b0, cyc + 2});
    @(posedge clk_i);
    #1;
    req_valid_i = 2'b00;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
